frame_serializer: RTL and testbench
===================================

// Module: frame_serializer
// PURPOSE
//  Transmit-side framer, directly upstream of the spreading stage. Accepts payload bytes on a
//  valid/ready stream and emits a serial bit stream: fixed preamble, payload MSB-first, then CRC-8.
//  Its bit output drives the spreader's data/valid input.
//  Buffers one byte ahead so the payload can be serialised back-to-back without gaps.
// PARAMETERS
//  PREAMBLE_W  16        preamble length in bits (>=1)
//  PREAMBLE    16'hF0A5  preamble pattern, sent MSB (bit PREAMBLE_W-1) first
//  CRC_POLY    8'h07     CRC-8 polynomial, non-reflected
//  CRC_INIT    8'h00     CRC register value loaded at each frame start
// PORTS
//  i_clk          in   1  clock
//  i_reset        in   1  reset, asynchronous, active-high
//  i_byte         in   8  payload byte
//  i_byte_last    in   1  marks the final byte of the frame
//  i_byte_valid   in   1  byte qualifier
//  o_byte_ready   out  1  byte accepted on an edge where valid&ready
//  o_bit          out  1  serial bit to spreader
//  o_bit_valid    out  1  o_bit qualifier
//  i_bit_ready    in   1  bit consumed on an edge where o_bit_valid&i_bit_ready
//  o_busy         out  1  frame in progress (state != IDLE)
//  o_frame_done   out  1  one-cycle pulse after the last CRC bit transfers
// BEHAVIOUR
//  - Reset (async, any time incl. mid-frame): state=IDLE, hold buffer empty, CRC=CRC_INIT, counters 0.
//    Outputs o_bit=0, o_bit_valid=0, o_busy=0, o_frame_done=0. o_byte_ready=0 while i_reset=1.
//    A partially sent frame is abandoned; no CRC is emitted.
//  - Storage: shift reg (byte being sent) + one-entry hold reg (byte+last).
//    o_byte_ready = ~hold_full; it is combinational from registered state only.
//  - FSM IDLE -> PREAMBLE -> PAYLOAD -> CRC -> IDLE.
//  - IDLE: o_bit_valid=0. A byte held in hold reg (or arriving) moves to shift reg at the next edge.
//    That edge also loads CRC=CRC_INIT and bit counter=PREAMBLE_W-1, and enters PREAMBLE.
//  - PREAMBLE: o_bit=PREAMBLE[cnt], o_bit_valid=1. Each transfer decrements cnt.
//    The transfer at cnt=0 enters PAYLOAD with bit idx=7.
//  - PAYLOAD: o_bit=shift[7], o_bit_valid=1 while the shift reg holds a byte.
//    Each transfer: crc <= {crc[6:0],1'b0} ^ ((crc[7]^o_bit) ? CRC_POLY : 0); shift left; idx--.
//  - Transfer of bit idx 0, current byte last=1: enter CRC with cnt=7.
//  - Transfer of bit idx 0, last=0, hold full: load hold into shift on the same edge, idx=7, no gap.
//    Hold-reg write on that same edge is allowed: load and refill happen simultaneously.
//  - Transfer of bit idx 0, last=0, hold empty: underrun. o_bit_valid=0 until a byte arrives.
//    That byte loads straight into the shift reg; the CRC keeps accumulating.
//  - CRC: o_bit=crc[cnt] (MSB first), o_bit_valid=1, CRC frozen. Transfer at cnt=0 goes to IDLE.
//    That transfer also raises o_frame_done for the next cycle.
//  - A new frame's first byte may be accepted into hold during CRC. It starts PREAMBLE from IDLE,
//    so there is 1 idle cycle minimum between frames.
//  - Backpressure: while o_bit_valid & ~i_bit_ready, o_bit and all state hold stable.
//    Bytes may still fill hold.
//  - Latency: first preamble bit valid 1 cycle after the accepting edge of the first byte in IDLE.
//  - Frame length in bits = PREAMBLE_W + 8*N + 8 for N payload bytes; N>=1, no upper limit.
// TESTING
//  1 Reset, i_bit_ready=1, send byte 0x01 last=1.
//    -> bits F0A5 (16), 00000001, CRC 00000111 (0x07); o_frame_done pulse; o_bit_valid low for 1+ cycle.
//  2 Frame "123456789" (0x31..0x39) back-to-back, ready=1.
//    -> contiguous 16+72+8 valid bits, no gaps, CRC 0xF4.
//  3 Same as 1 with i_bit_ready toggled 1010... and random stalls.
//    -> identical bit sequence; o_bit stable during every stall.
//  4 Two-byte frame 0xAA, 0x55 with second byte 20 cycles late.
//    -> o_bit_valid low after 0xAA bit 0 until 0x55 arrives; CRC equals ungapped case.
//  5 Assert i_reset mid-payload, then send byte 0x00 last=1.
//    -> outputs 0 during reset; new frame F0A5, 0x00, CRC 0x00; no residue.
//  6 Two single-byte frames, second offered during first's CRC.
//    -> accepted into hold; exactly one idle cycle; second preamble starts clean with CRC re-initialised.

Source files
------------

// File: rtl/frame_serializer.sv
// frame_serializer
//   Transmit-side framer feeding the spreading stage. Accepts payload bytes on a
//   valid/ready stream and emits a serial bit stream: fixed preamble, payload
//   MSB-first, then a CRC-8 over the payload. A one-entry hold register sits in
//   front of the shift register so consecutive payload bytes go out back-to-back.
//
// Ports
//   i_clk         in   clock
//   i_reset       in   asynchronous, active-high reset
//   i_byte        in   payload byte
//   i_byte_last   in   marks the final byte of the frame
//   i_byte_valid  in   byte qualifier
//   o_byte_ready  out  byte accepted on an edge where valid & ready
//   o_bit         out  serial bit to the spreader
//   o_bit_valid   out  o_bit qualifier
//   i_bit_ready   in   bit consumed on an edge where o_bit_valid & i_bit_ready
//   o_busy        out  frame in progress
//   o_frame_done  out  one-cycle pulse after the last CRC bit transfers
//
// States
//   S_IDLE     | no frame; waits for a byte in hold or on the input
//   S_PREAMBLE | sending PREAMBLE[cnt], MSB first
//   S_PAYLOAD  | sending shift[7]; idle (bit invalid) on underrun
//   S_CRC      | sending crc[cnt], MSB first, CRC frozen

module frame_serializer #(
    parameter int                    PREAMBLE_W = 16,
    parameter logic [PREAMBLE_W-1:0] PREAMBLE   = 16'hF0A5,
    parameter logic [7:0]            CRC_POLY   = 8'h07,
    parameter logic [7:0]            CRC_INIT   = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_byte,
    input  logic       i_byte_last,
    input  logic       i_byte_valid,
    output logic       o_byte_ready,
    output logic       o_bit,
    output logic       o_bit_valid,
    input  logic       i_bit_ready,
    output logic       o_busy,
    output logic       o_frame_done
);

    // Counter is shared between preamble index and payload/CRC bit index.
    localparam int CNT_W = (PREAMBLE_W > 8) ? $clog2(PREAMBLE_W) : 3;

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_PAYLOAD, S_CRC} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             shift_last_q, shift_last_d;
    logic             shift_full_q, shift_full_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_last_q, hold_last_d;
    logic             hold_full_q, hold_full_d;
    logic [7:0]       crc_q, crc_d;
    logic             done_q, done_d;

    logic             accept;
    logic             xfer;
    logic             byte_avail;
    logic [7:0]       next_byte;
    logic             next_last;
    logic             load_shift;
    logic             fb;

    assign o_byte_ready = ~hold_full_q & ~i_reset;
    assign accept       = i_byte_valid & o_byte_ready;
    assign o_busy       = (state_q != S_IDLE);
    assign o_frame_done = done_q;

    // The hold register is the preferred source; otherwise an arriving byte
    // bypasses hold and goes straight into the shift register.
    assign byte_avail = hold_full_q | accept;
    assign next_byte  = hold_full_q ? hold_q : i_byte;
    assign next_last  = hold_full_q ? hold_last_q : i_byte_last;

    always_comb begin
        o_bit       = 1'b0;
        o_bit_valid = 1'b0;
        case (state_q)
            S_PREAMBLE: begin
                o_bit       = PREAMBLE[cnt_q];
                o_bit_valid = 1'b1;
            end
            S_PAYLOAD: begin
                o_bit       = shift_q[7] & shift_full_q;
                o_bit_valid = shift_full_q;
            end
            S_CRC: begin
                o_bit       = crc_q[cnt_q[2:0]];
                o_bit_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign xfer = o_bit_valid & i_bit_ready;
    assign fb   = crc_q[7] ^ o_bit;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        shift_last_d = shift_last_q;
        shift_full_d = shift_full_q;
        hold_d       = hold_q;
        hold_last_d  = hold_last_q;
        hold_full_d  = hold_full_q;
        crc_d        = crc_q;
        done_d       = 1'b0;
        load_shift   = 1'b0;

        if (accept) begin
            hold_d      = i_byte;
            hold_last_d = i_byte_last;
            hold_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (byte_avail) begin
                    load_shift = 1'b1;
                    crc_d      = CRC_INIT;
                    cnt_d      = CNT_W'(PREAMBLE_W - 1);
                    state_d    = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                if (xfer) begin
                    if (cnt_q == '0) begin
                        cnt_d   = CNT_W'(7);
                        state_d = S_PAYLOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (shift_full_q) begin
                    if (xfer) begin
                        crc_d   = {crc_q[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
                        shift_d = {shift_q[6:0], 1'b0};
                        if (cnt_q == '0) begin
                            if (shift_last_q) begin
                                shift_full_d = 1'b0;
                                cnt_d        = CNT_W'(7);
                                state_d      = S_CRC;
                            end else if (byte_avail) begin
                                load_shift = 1'b1;
                                cnt_d      = CNT_W'(7);
                            end else begin
                                shift_full_d = 1'b0;
                            end
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end else if (byte_avail) begin
                    // Underrun recovery: CRC is left accumulating.
                    load_shift = 1'b1;
                    cnt_d      = CNT_W'(7);
                end
            end
            S_CRC: begin
                if (xfer) begin
                    if (cnt_q == '0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // accept is only possible with hold empty, so a load always leaves
        // hold empty: either hold was drained or the new byte bypassed it.
        if (load_shift) begin
            shift_d      = next_byte;
            shift_last_d = next_last;
            shift_full_d = 1'b1;
            hold_full_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shift_q      <= 8'h00;
            shift_last_q <= 1'b0;
            shift_full_q <= 1'b0;
            hold_q       <= 8'h00;
            hold_last_q  <= 1'b0;
            hold_full_q  <= 1'b0;
            crc_q        <= CRC_INIT;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            shift_last_q <= shift_last_d;
            shift_full_q <= shift_full_d;
            hold_q       <= hold_d;
            hold_last_q  <= hold_last_d;
            hold_full_q  <= hold_full_d;
            crc_q        <= crc_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_frame_serializer.sv
// tb_frame_serializer
//   Scoreboard bench for frame_serializer. Stimulus pushes the expected bit
//   stream of each frame (preamble, payload MSB-first, byte-wise CRC-8) into a
//   queue; a negedge monitor pops and compares on every bit transfer, and also
//   checks stall stability, the done pulse and reset outputs.

module tb_frame_serializer;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_byte;
    logic       i_byte_last;
    logic       i_byte_valid;
    logic       o_byte_ready;
    logic       o_bit;
    logic       o_bit_valid;
    logic       i_bit_ready;
    logic       o_busy;
    logic       o_frame_done;

    frame_serializer dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_byte       (i_byte),
        .i_byte_last  (i_byte_last),
        .i_byte_valid (i_byte_valid),
        .o_byte_ready (o_byte_ready),
        .o_bit        (o_bit),
        .o_bit_valid  (o_bit_valid),
        .i_bit_ready  (i_bit_ready),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic b;
        logic first;
        logic last;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] bq[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         ready_mode = 0;
    int         start_cyc = 0;
    int         end_cyc = -1000;
    int         last_span = 0;
    int         last_gap = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] crc8(input logic [7:0] d[$]);
        logic [7:0] c;
        c = 8'h00;
        foreach (d[i]) begin
            c = c ^ d[i];
            for (int k = 0; k < 8; k++)
                c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    task automatic push_frame(input logic [7:0] d[$], input bit with_crc);
        logic [15:0] pre;
        logic [7:0]  c;
        exp_t        e;
        pre = 16'hF0A5;
        for (int i = 15; i >= 0; i--) begin
            e.b = pre[i]; e.first = (i == 15); e.last = 1'b0;
            exp_q.push_back(e);
        end
        foreach (d[n]) begin
            for (int j = 7; j >= 0; j--) begin
                e.b = d[n][j]; e.first = 1'b0; e.last = 1'b0;
                exp_q.push_back(e);
            end
        end
        if (with_crc) begin
            c = crc8(d);
            for (int j = 7; j >= 0; j--) begin
                e.b = c[j]; e.first = 1'b0; e.last = (j == 0);
                exp_q.push_back(e);
            end
        end
    endtask

    // Called just after a posedge; returns just after the accepting posedge
    // (or at the following negedge when the latency check is requested).
    task automatic offer(input logic [7:0] b, input logic last, input bit chk_latency);
        int n;
        i_byte       = b;
        i_byte_last  = last;
        i_byte_valid = 1'b1;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_byte_ready && n < 2000);
        if (!o_byte_ready) chk("byte_accept_timeout", 32'd0, 32'd1);
        @(posedge i_clk);
        #1;
        i_byte_valid = 1'b0;
        if (chk_latency) begin
            @(negedge i_clk);
            chk("first_bit_latency", o_bit_valid, 1);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge i_clk);
            n++;
        end
        chk("drain_remaining", exp_q.size(), 0);
        repeat (3) @(negedge i_clk);
        chk("idle_after_frame", {o_busy, o_bit_valid}, 0);
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_size_le(input int lim);
        int n;
        n = 0;
        while (exp_q.size() > lim && n < 4000) begin
            @(negedge i_clk);
            n++;
        end
        chk("wait_progress", exp_q.size() <= lim, 1);
    endtask

    initial begin
        i_bit_ready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            case (ready_mode)
                1:       i_bit_ready = ~i_bit_ready;
                2:       i_bit_ready = 1'($urandom_range(0, 1));
                default: i_bit_ready = 1'b1;
            endcase
        end
    end

    // Monitor
    initial begin
        logic prev_stall;
        logic prev_bit;
        logic exp_done;
        exp_t e;
        prev_stall = 1'b0;
        prev_bit   = 1'b0;
        exp_done   = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_reset) begin
                chk("reset_outputs", {o_bit, o_bit_valid, o_busy, o_frame_done, o_byte_ready}, 0);
                prev_stall = 1'b0;
                exp_done   = 1'b0;
            end else begin
                chk("frame_done", o_frame_done, exp_done);
                exp_done = 1'b0;
                if (prev_stall) chk("stall_hold", {o_bit_valid, o_bit}, {1'b1, prev_bit});
                prev_stall = o_bit_valid & ~i_bit_ready;
                prev_bit   = o_bit;
                if (o_bit_valid && i_bit_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_bit", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("bit", o_bit, e.b);
                        if (e.first) begin
                            last_gap  = cyc - end_cyc;
                            start_cyc = cyc;
                        end
                        if (e.last) begin
                            end_cyc   = cyc;
                            last_span = cyc - start_cyc;
                            exp_done  = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        repeat (60000) @(posedge i_clk);
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        i_reset      = 1'b1;
        i_byte       = 8'h00;
        i_byte_last  = 1'b0;
        i_byte_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;

        // 1: single byte 0x01
        bq = {};
        bq.push_back(8'h01);
        push_frame(bq, 1);
        offer(8'h01, 1'b1, 1'b1);
        wait_drain();

        // 2: "123456789" back-to-back
        bq = {};
        for (int i = 0; i < 9; i++) bq.push_back(8'h31 + 8'(i));
        push_frame(bq, 1);
        for (int i = 0; i < 9; i++) offer(bq[i], (i == 8), 1'b0);
        wait_drain();
        chk("t2_contiguous_span", last_span, 95);

        // 3: single byte with toggled, then random, ready
        for (int m = 1; m <= 2; m++) begin
            ready_mode = m;
            bq = {};
            bq.push_back(8'h01);
            push_frame(bq, 1);
            offer(8'h01, 1'b1, 1'b0);
            wait_drain();
        end
        ready_mode = 0;
        @(posedge i_clk);
        #1;

        // 4: 0xAA then 0x55 twenty cycles late
        bq = {};
        bq.push_back(8'hAA);
        bq.push_back(8'h55);
        push_frame(bq, 1);
        offer(8'hAA, 1'b0, 1'b0);
        wait_size_le(16);
        repeat (20) @(negedge i_clk);
        chk("t4_underrun_valid_low", {o_busy, o_bit_valid}, 2'b10);
        @(posedge i_clk);
        #1;
        offer(8'h55, 1'b1, 1'b0);
        wait_drain();
        chk("t4_gapped_span", last_span >= 59, 1);

        // 5: reset mid-payload, then 0x00
        bq = {};
        bq.push_back(8'hC3);
        push_frame(bq, 0);
        offer(8'hC3, 1'b0, 1'b0);
        wait_size_le(4);
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        exp_q.delete();
        repeat (3) @(negedge i_clk);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        bq = {};
        bq.push_back(8'h00);
        push_frame(bq, 1);
        offer(8'h00, 1'b1, 1'b1);
        wait_drain();

        // 6: second frame offered during first frame's CRC
        bq = {};
        bq.push_back(8'h5A);
        push_frame(bq, 1);
        offer(8'h5A, 1'b1, 1'b0);
        wait_size_le(8);
        @(posedge i_clk);
        #1;
        bq = {};
        bq.push_back(8'hC6);
        push_frame(bq, 1);
        offer(8'hC6, 1'b1, 1'b0);
        chk("t6_accepted_during_crc", o_busy, 1);
        wait_drain();
        chk("t6_frame_gap", last_gap, 2);

        // Random frames with random ready and random byte spacing
        for (int k = 0; k < 8; k++) begin
            ready_mode = k % 3;
            nb = $urandom_range(1, 4);
            bq = {};
            for (int i = 0; i < nb; i++) bq.push_back(8'($urandom_range(0, 255)));
            push_frame(bq, 1);
            for (int i = 0; i < nb; i++) begin
                repeat ($urandom_range(0, 12)) @(posedge i_clk);
                #1;
                offer(bq[i], (i == nb - 1), 1'b0);
            end
            wait_drain();
        end
        ready_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
